// File: rtl/imem_loader.sv
// Loads a valid/ready stream of machine-code words into the instruction memory,
// holds the core in reset while loading, then runs it until cpu_done re-arms the loader.
module imem_loader #(
   parameter int DATA_W    = 9,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int START_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              cpu_start,
   input  logic              cpu_done,
   output logic [ADDR_W:0]   prog_len,
   output logic              busy,
   output logic              err_ovf
);

   localparam int CNT_W = $clog2(START_CYC + 2);

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ERR} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W:0]   prog_len_next;
   logic              err_next;
   logic              wr_en_next;
   logic              accept;

   assign accept = in_valid & in_ready;

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      cnt_next      = cnt_reg;
      prog_len_next = prog_len;
      err_next      = err_ovf;
      wr_en_next    = 1'b0;
      case (state_reg)
         IDLE, LOAD: begin
            if (accept) begin
               wr_en_next  = 1'b1;
               wr_ptr_next = wr_ptr_reg + 1'b1;
               if (in_last) begin
                  prog_len_next = (ADDR_W+1)'(wr_ptr_reg) + (ADDR_W+1)'(1);
                  cnt_next      = '0;
                  state_next    = START;
               end else if (wr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                  err_next   = 1'b1;
                  state_next = ERR;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         // cnt_reg==0 is the cycle of the final write; hold START_CYC more cycles
         START: begin
            if (cnt_reg == CNT_W'(START_CYC)) begin
               cnt_next   = '0;
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         // cnt_reg==0 marks the first RUN cycle, where cpu_done may still be stale
         RUN: begin
            cnt_next = CNT_W'(1);
            if (cnt_reg != '0 && cpu_done) begin
               wr_ptr_next = '0;
               state_next  = IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         wr_ptr_reg  <= '0;
         cnt_reg     <= '0;
         in_ready    <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         cpu_start   <= 1'b1;
         prog_len    <= '0;
         busy        <= 1'b0;
         err_ovf     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wr_ptr_reg <= wr_ptr_next;
         cnt_reg    <= cnt_next;
         in_ready   <= (state_next == IDLE) || (state_next == LOAD);
         mem_wr_en  <= wr_en_next;
         if (wr_en_next) begin
            mem_wr_addr <= wr_ptr_reg;
            mem_wr_data <= in_data;
         end
         cpu_start <= (state_next != RUN);
         prog_len  <= prog_len_next;
         busy      <= (state_next == LOAD) || (state_next == START) || (state_next == RUN);
         err_ovf   <= err_next;
      end
   end

endmodule
